// File: rtl/mem_bus_if.sv
// Single-word valid/ready memory bus between an initiator
// and a responder.
interface mem_bus_if;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_valid,
    output mem_addr,
    output mem_wdata,
    output mem_wstrb,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_valid,
    input  mem_addr,
    input  mem_wdata,
    input  mem_wstrb,
    output mem_rdata,
    output mem_ready
  );
endinterface

// File: rtl/mem_bus_bridge_initiator.sv
// Byte-stream command parser that issues single-word reads and
// writes on the memory bus and streams status/data back out.
module mem_bus_bridge_initiator #(
  parameter int BUS_TIMEOUT  = 1024,
  parameter int BYTE_TIMEOUT = 65536
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_rx_valid,
  input  logic [7:0] i_rx_data,
  output logic       o_tx_valid,
  output logic [7:0] o_tx_data,
  input  logic       i_tx_ready,
  mem_bus_if.master  bus,
  output logic       o_busy,
  output logic       o_overrun
);

  localparam int BUS_W  = $clog2(BUS_TIMEOUT);
  localparam int BYTE_W = $clog2(BYTE_TIMEOUT);
  localparam logic [BUS_W-1:0] BUS_LAST =
    BUS_W'(BUS_TIMEOUT - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST =
    BYTE_W'(BYTE_TIMEOUT - 1);

  localparam logic [7:0] C_RD  = 8'h52;
  localparam logic [7:0] C_WR  = 8'h57;
  localparam logic [7:0] C_OK  = 8'h4B;
  localparam logic [7:0] C_BAD = 8'h3F;
  localparam logic [7:0] C_TO  = 8'h54;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BUS,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic              r_is_wr;
  logic [1:0]        r_cnt;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_wstrb;
  logic [31:0]       r_resp;
  logic [1:0]        r_idx;
  logic [1:0]        r_last;
  logic [BYTE_W-1:0] r_byte_tmr;
  logic [BUS_W-1:0]  r_bus_tmr;
  logic              r_overrun;

  logic w_cmd_ok;
  logic w_byte_to;
  logic w_bus_to;
  logic w_tx_hs;
  logic w_rx_last;

  assign w_cmd_ok  = (i_rx_data == C_RD) ||
                     (i_rx_data == C_WR);
  assign w_byte_to = (r_byte_tmr == BYTE_LAST);
  assign w_bus_to  = (r_bus_tmr == BUS_LAST);
  assign w_tx_hs   = o_tx_valid && i_tx_ready;
  assign w_rx_last = i_rx_valid && (r_cnt == 2'd3);

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (i_rx_valid)
          w_next = w_cmd_ok ? S_ADDR : S_RESP;
      end
      S_ADDR: begin
        if (w_rx_last)
          w_next = r_is_wr ? S_DATA : S_BUS;
        else if (!i_rx_valid && w_byte_to)
          w_next = S_IDLE;
      end
      S_DATA: begin
        if (w_rx_last)
          w_next = S_BUS;
        else if (!i_rx_valid && w_byte_to)
          w_next = S_IDLE;
      end
      // ready outranks a timeout landing on the same cycle
      S_BUS: begin
        if (bus.mem_ready || w_bus_to)
          w_next = S_RESP;
      end
      S_RESP: begin
        if (w_tx_hs && (r_idx == r_last))
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy         = (r_state != S_IDLE);
    bus.mem_valid  = (r_state == S_BUS);
    o_tx_valid     = (r_state == S_RESP);
    o_tx_data      = 8'h00;
    if (o_tx_valid)
      o_tx_data = r_resp[{r_idx, 3'b000} +: 8];
    bus.mem_addr   = {r_addr[31:2], 2'b00};
    bus.mem_wdata  = r_wdata;
    bus.mem_wstrb  = r_wstrb;
    o_overrun      = r_overrun;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_is_wr    <= 1'b0;
      r_cnt      <= 2'd0;
      r_addr     <= 32'h0;
      r_wdata    <= 32'h0;
      r_wstrb    <= 4'h0;
      r_resp     <= 32'h0;
      r_idx      <= 2'd0;
      r_last     <= 2'd0;
      r_byte_tmr <= '0;
      r_bus_tmr  <= '0;
      r_overrun  <= 1'b0;
    end else begin
      if (i_rx_valid &&
          (r_state == S_BUS || r_state == S_RESP))
        r_overrun <= 1'b1;
      unique case (r_state)
        S_IDLE: begin
          r_cnt      <= 2'd0;
          r_byte_tmr <= '0;
          r_bus_tmr  <= '0;
          r_idx      <= 2'd0;
          if (i_rx_valid) begin
            if (w_cmd_ok) begin
              r_is_wr <= (i_rx_data == C_WR);
              r_wstrb <= (i_rx_data == C_WR) ?
                         4'hF : 4'h0;
            end else begin
              r_resp <= {24'h0, C_BAD};
              r_last <= 2'd0;
            end
          end
        end
        S_ADDR, S_DATA: begin
          if (i_rx_valid) begin
            r_cnt      <= r_cnt + 2'd1;
            r_byte_tmr <= '0;
            // little-endian: newest byte lands in the MSB
            if (r_state == S_ADDR)
              r_addr  <= {i_rx_data, r_addr[31:8]};
            else
              r_wdata <= {i_rx_data, r_wdata[31:8]};
          end else if (!w_byte_to) begin
            r_byte_tmr <= r_byte_tmr + 1'b1;
          end
        end
        S_BUS: begin
          if (bus.mem_ready) begin
            r_resp <= r_is_wr ? {24'h0, C_OK} :
                      bus.mem_rdata;
            r_last <= r_is_wr ? 2'd0 : 2'd3;
          end else if (w_bus_to) begin
            r_resp <= {24'h0, C_TO};
            r_last <= 2'd0;
          end else begin
            r_bus_tmr <= r_bus_tmr + 1'b1;
          end
        end
        S_RESP: begin
          if (w_tx_hs)
            r_idx <= r_idx + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_bridge_initiator.sv
// Directed bench for the byte-stream memory bus bridge:
// read/write/bad/timeout/byte-timeout/overrun/reset scenarios.
module tb_mem_bus_bridge_initiator;

  logic       clk;
  logic       reset;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       busy;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  int valid_cycles = 0;
  int tx_cycles = 0;

  mem_bus_if u_bus ();

  mem_bus_bridge_initiator #(
    .BUS_TIMEOUT (16),
    .BYTE_TIMEOUT(32)
  ) dut (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_rx_valid(rx_valid),
    .i_rx_data (rx_data),
    .o_tx_valid(tx_valid),
    .o_tx_data (tx_data),
    .i_tx_ready(tx_ready),
    .bus       (u_bus),
    .o_busy    (busy),
    .o_overrun (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (u_bus.mem_valid === 1'b1)
      valid_cycles <= valid_cycles + 1;
    if (tx_valid === 1'b1)
      tx_cycles <= tx_cycles + 1;
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_tx: valid=%b data=%h want 0 00",
               tx_valid, tx_data);
    end
    checks++;
    if (u_bus.mem_valid !== 1'b0 ||
        u_bus.mem_addr !== 32'h0 ||
        u_bus.mem_wdata !== 32'h0 ||
        u_bus.mem_wstrb !== 4'h0) begin
      errors++;
      $display("FAIL reset_bus: v=%b a=%h d=%h s=%h want 0",
               u_bus.mem_valid, u_bus.mem_addr,
               u_bus.mem_wdata, u_bus.mem_wstrb);
    end
    checks++;
    if (busy !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: busy=%b ovr=%b want 0 0",
               busy, overrun);
    end
  endtask

  task automatic test_write;
    logic [7:0] cmd [9];
    int v0;
    cmd = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h20,
            8'hEF, 8'hBE, 8'hAD, 8'hDE};
    v0 = valid_cycles;
    for (int i = 0; i < 9; i++) send_byte(cmd[i]);
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if (u_bus.mem_valid !== 1'b1 ||
          u_bus.mem_addr !== 32'h2000_0000 ||
          u_bus.mem_wdata !== 32'hDEAD_BEEF ||
          u_bus.mem_wstrb !== 4'hF) begin
        errors++;
        $display("FAIL write_bus c%0d: v=%b a=%h d=%h s=%h %s",
                 c, u_bus.mem_valid, u_bus.mem_addr,
                 u_bus.mem_wdata, u_bus.mem_wstrb,
                 "want 1 20000000 deadbeef f");
      end
      if (c == 3) u_bus.mem_ready = 1'b1;
      @(posedge clk); #1;
    end
    u_bus.mem_ready = 1'b0;
    checks++;
    if (valid_cycles - v0 !== 3 ||
        u_bus.mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL write_len: cycles=%0d v=%b want 3 0",
               valid_cycles - v0, u_bus.mem_valid);
    end
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h4B) begin
      errors++;
      $display("FAIL write_resp: v=%b d=%h want 1 4b",
               tx_valid, tx_data);
    end
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL write_idle: busy=%b tx=%b want 0 0",
               busy, tx_valid);
    end
  endtask

  task automatic test_read;
    logic [7:0] cmd [5];
    logic [7:0] exp [4];
    cmd = '{8'h52, 8'h07, 8'h00, 8'h00, 8'h10};
    exp = '{8'h78, 8'h56, 8'h34, 8'h12};
    for (int i = 0; i < 5; i++) send_byte(cmd[i]);
    checks++;
    if (u_bus.mem_valid !== 1'b1 ||
        u_bus.mem_addr !== 32'h1000_0004 ||
        u_bus.mem_wstrb !== 4'h0) begin
      errors++;
      $display("FAIL read_bus: v=%b a=%h s=%h %s",
               u_bus.mem_valid, u_bus.mem_addr,
               u_bus.mem_wstrb, "want 1 10000004 0");
    end
    u_bus.mem_ready = 1'b1;
    u_bus.mem_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    u_bus.mem_ready = 1'b0;
    u_bus.mem_rdata = 32'h0;
    checks++;
    if (u_bus.mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL read_drop: v=%b want 0",
               u_bus.mem_valid);
    end
    for (int i = 0; i < 4; i++) begin
      tx_ready = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp[i]) begin
        errors++;
        $display("FAIL read_hold b%0d: v=%b d=%h want 1 %h",
                 i, tx_valid, tx_data, exp[i]);
      end
      tx_ready = 1'b1;
      @(posedge clk); #1;
    end
    tx_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL read_idle: busy=%b tx=%b want 0 0",
               busy, tx_valid);
    end
  endtask

  task automatic test_bad;
    int v0;
    v0 = valid_cycles;
    send_byte(8'h00);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h3F ||
        busy !== 1'b1) begin
      errors++;
      $display("FAIL bad_resp: v=%b d=%h busy=%b want 1 3f 1",
               tx_valid, tx_data, busy);
    end
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || valid_cycles != v0) begin
      errors++;
      $display("FAIL bad_idle: busy=%b buscyc=%0d want 0 0",
               busy, valid_cycles - v0);
    end
  endtask

  task automatic test_timeout;
    logic [7:0] cmd [5];
    logic [7:0] cmd2 [5];
    logic [31:0] word;
    int v0;
    cmd  = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h30};
    cmd2 = '{8'h52, 8'h04, 8'h00, 8'h00, 8'h10};
    word = 32'hCAFE_F00D;
    v0 = valid_cycles;
    for (int i = 0; i < 5; i++) send_byte(cmd[i]);
    for (int k = 0; k < 40 && tx_valid !== 1'b1; k++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h54) begin
      errors++;
      $display("FAIL to_resp: v=%b d=%h want 1 54",
               tx_valid, tx_data);
    end
    checks++;
    if (valid_cycles - v0 != 16 ||
        u_bus.mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL to_len: cycles=%0d v=%b want 16 0",
               valid_cycles - v0, u_bus.mem_valid);
    end
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL to_idle: busy=%b want 0", busy);
    end
    for (int i = 0; i < 5; i++) send_byte(cmd2[i]);
    checks++;
    if (u_bus.mem_valid !== 1'b1 ||
        u_bus.mem_addr !== 32'h1000_0004) begin
      errors++;
      $display("FAIL to_next_bus: v=%b a=%h want 1 10000004",
               u_bus.mem_valid, u_bus.mem_addr);
    end
    u_bus.mem_ready = 1'b1;
    u_bus.mem_rdata = word;
    @(posedge clk); #1;
    u_bus.mem_ready = 1'b0;
    u_bus.mem_rdata = 32'h0;
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tx_valid !== 1'b1 ||
          tx_data !== word[8*i +: 8]) begin
        errors++;
        $display("FAIL to_next_b%0d: v=%b d=%h want 1 %h",
                 i, tx_valid, tx_data, word[8*i +: 8]);
      end
      @(posedge clk); #1;
    end
    tx_ready = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL to_next_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_byte_timeout;
    logic [7:0] cmd [5];
    logic [31:0] word;
    int t0;
    int v0;
    cmd  = '{8'h52, 8'h08, 8'h00, 8'h00, 8'h10};
    word = 32'h0BAD_C0DE;
    t0 = tx_cycles;
    v0 = valid_cycles;
    send_byte(8'h57);
    send_byte(8'h01);
    send_byte(8'h02);
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL bt_wait: busy=%b want 1", busy);
    end
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || tx_cycles != t0 ||
        valid_cycles != v0) begin
      errors++;
      $display("FAIL bt_drop: busy=%b tx=%0d bus=%0d %s",
               busy, tx_cycles - t0, valid_cycles - v0,
               "want 0 0 0");
    end
    for (int i = 0; i < 5; i++) send_byte(cmd[i]);
    checks++;
    if (u_bus.mem_valid !== 1'b1 ||
        u_bus.mem_addr !== 32'h1000_0008 ||
        overrun !== 1'b0) begin
      errors++;
      $display("FAIL bt_bus: v=%b a=%h ovr=%b %s",
               u_bus.mem_valid, u_bus.mem_addr, overrun,
               "want 1 10000008 0");
    end
    send_byte(8'hAA);
    checks++;
    if (overrun !== 1'b1 || u_bus.mem_valid !== 1'b1) begin
      errors++;
      $display("FAIL overrun: ovr=%b v=%b want 1 1",
               overrun, u_bus.mem_valid);
    end
    u_bus.mem_ready = 1'b1;
    u_bus.mem_rdata = word;
    @(posedge clk); #1;
    u_bus.mem_ready = 1'b0;
    u_bus.mem_rdata = 32'h0;
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tx_valid !== 1'b1 ||
          tx_data !== word[8*i +: 8]) begin
        errors++;
        $display("FAIL bt_read_b%0d: v=%b d=%h want 1 %h",
                 i, tx_valid, tx_data, word[8*i +: 8]);
      end
      @(posedge clk); #1;
    end
    tx_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL bt_end: busy=%b ovr=%b want 0 1",
               busy, overrun);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] cmd [5];
    cmd = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h10};
    for (int i = 0; i < 5; i++) send_byte(cmd[i]);
    checks++;
    if (u_bus.mem_valid !== 1'b1) begin
      errors++;
      $display("FAIL rmid_pre: v=%b want 1", u_bus.mem_valid);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (u_bus.mem_valid !== 1'b0 || busy !== 1'b0 ||
        tx_valid !== 1'b0 || overrun !== 1'b0 ||
        u_bus.mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL rmid: v=%b busy=%b tx=%b ovr=%b a=%h %s",
               u_bus.mem_valid, busy, tx_valid, overrun,
               u_bus.mem_addr, "want 0 0 0 0 0");
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    reset           = 1'b1;
    rx_valid        = 1'b0;
    rx_data         = 8'h00;
    tx_ready        = 1'b0;
    u_bus.mem_ready = 1'b0;
    u_bus.mem_rdata = 32'h0;
    test_reset;
    test_write;
    test_read;
    test_bad;
    test_timeout;
    test_byte_timeout;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
